// File: rtl/fetch_unit.sv
// Instruction fetch stage: icache request FSM, redirect handling and fetch queue.
// Optional FETCH_JAL_PREDICT_EN: follow JAL targets instead of PC+4.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0010,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PCF,
    output logic        IMRead,
    input  logic [31:0] InstrF,
    input  logic        IMRdy,
    output logic        InstrValidD,
    input  logic        InstrReadyD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    input  logic        RedirectE,
    input  logic [31:0] RedirectPC
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(QDEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]    state;
    logic [31:0]   drop_pc;
    logic [31:0]   pc_mem    [QDEPTH];
    logic [31:0]   instr_mem [QDEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          enq;
    logic          deq;
    logic [31:0]   redirect_pc;
    logic [31:0]   seq_pc;

    assign redirect_pc = RedirectPC & ~32'h3;
    // A redirect discards any response arriving in the same cycle
    assign enq = (state == S_REQ) && IMRdy && !RedirectE;
    assign deq = InstrValidD && InstrReadyD;

    always_comb begin
        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

`ifdef FETCH_JAL_PREDICT_EN
    logic [31:0] jal_imm;
    logic        is_jal;

    assign jal_imm = {{12{InstrF[31]}}, InstrF[19:12], InstrF[20],
                      InstrF[30:21], 1'b0};
    assign is_jal  = (InstrF[6:0] == 7'b1101111);
    assign seq_pc  = is_jal ? PCF + jal_imm : PCF + 32'd4;
`else
    assign seq_pc  = PCF + 32'd4;
`endif

    assign InstrValidD = (count != '0);
    assign InstrD      = InstrValidD ? instr_mem[rptr] : '0;
    assign PCD         = InstrValidD ? pc_mem[rptr]    : '0;

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wptr]    <= PCF;
            instr_mem[wptr] <= InstrF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || RedirectE) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            PCF     <= RESET_PC;
            IMRead  <= 1'b0;
            drop_pc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state  <= S_REQ;
                    IMRead <= 1'b1;
                    if (RedirectE) PCF <= redirect_pc;
                end
                S_REQ: begin
                    if (RedirectE) begin
                        if (IMRdy) begin
                            PCF <= redirect_pc;
                        end else begin
                            drop_pc <= redirect_pc;
                            state   <= S_DROP;
                        end
                    end else if (IMRdy) begin
                        PCF <= seq_pc;
                        if (count_next == DEPTH) begin
                            state  <= S_WAIT;
                            IMRead <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (RedirectE) begin
                        PCF    <= redirect_pc;
                        IMRead <= 1'b1;
                        state  <= S_REQ;
                    end else if (count_next < DEPTH) begin
                        IMRead <= 1'b1;
                        state  <= S_REQ;
                    end
                end
                S_DROP: begin
                    // The in-flight request cannot be aborted; retire it first
                    if (IMRdy) begin
                        PCF   <= RedirectE ? redirect_pc : drop_pc;
                        state <= S_REQ;
                    end else if (RedirectE) begin
                        drop_pc <= redirect_pc;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    IMRead <= 1'b0;
                end
            endcase
        end
    end

endmodule
